// File: rtl/lsm_uop_sequencer.sv
// Multi-register load/store micro-op sequencer: expands PUSH/POP/STM/LDM into
// one transfer micro-op per register. Optional macro: LSM_SEPARATE_WB_EN.
module lsm_uop_sequencer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [1:0] op_i,
  input  logic [2:0] base_reg_i,
  input  logic [8:0] reg_list_i,
  input  logic       advance_i,
  output logic       busy_o,
  output logic       stall_o,
  output logic       uop_valid_o,
  output logic [3:0] uop_reg_addr_o,
  output logic [3:0] uop_base_addr_o,
  output logic [5:0] uop_offset_o,
  output logic       uop_is_load_o,
  output logic       uop_is_wb_o,
  output logic       uop_last_o,
  output logic [5:0] total_bytes_o
);

`ifdef LSM_SEPARATE_WB_EN
  typedef enum logic [1:0] {IDLE, XFER, WB} state_t;
`else
  typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

  typedef enum logic [1:0] {OP_PUSH = 2'b00, OP_POP = 2'b01, OP_STM = 2'b10, OP_LDM = 2'b11} op_t;

  state_t     state_q, state_d;
  op_t        op_q, op_d;
  logic [3:0] base_q, base_d;
  logic [8:0] pending_q, pending_d;
  logic [3:0] idx_q, idx_d;
  logic [5:0] total_q, total_d;
  logic       wb_req_q, wb_req_d;

  logic [8:0] eff_list;
  logic [3:0] eff_count;
  logic       start_ok;
  logic [8:0] low_onehot;
  logic [3:0] low_idx;
  logic       last_xfer;

  // STM/LDM have no ninth register; bit8 only means LR/PC for PUSH/POP.
  always_comb begin
    eff_list = reg_list_i;
    if (op_i[1]) eff_list[8] = 1'b0;
    eff_count = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      eff_count = eff_count + 4'(eff_list[i]);
    end
    start_ok = start_i && (state_q == IDLE) && (eff_list != '0);
  end

  always_comb begin
    low_onehot = pending_q & (~pending_q + 9'd1);
    low_idx    = '0;
    for (int unsigned i = 9; i > 0; i--) begin
      if (pending_q[i-1]) low_idx = 4'(i - 1);
    end
    last_xfer = (pending_q & ~low_onehot) == '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= OP_PUSH;
      base_q    <= '0;
      pending_q <= '0;
      idx_q     <= '0;
      total_q   <= '0;
      wb_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      base_q    <= base_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      total_q   <= total_d;
      wb_req_q  <= wb_req_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    base_d    = base_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    total_d   = total_q;
    wb_req_d  = wb_req_q;

    busy_o          = state_q != IDLE;
    uop_valid_o     = busy_o;
    stall_o         = !rst_i && (busy_o || start_ok);
    uop_reg_addr_o  = '0;
    uop_base_addr_o = '0;
    uop_offset_o    = '0;
    uop_is_load_o   = 1'b0;
    uop_is_wb_o     = 1'b0;
    uop_last_o      = 1'b0;
    total_bytes_o   = busy_o ? total_q : '0;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d   = XFER;
          op_d      = op_t'(op_i);
          base_d    = op_i[1] ? {1'b0, base_reg_i} : 4'd13;
          pending_d = eff_list;
          idx_d     = '0;
          total_d   = {eff_count, 2'b00};
          // LDM that reloads its own base must not overwrite it with the writeback.
          wb_req_d  = !((op_t'(op_i) == OP_LDM) && reg_list_i[base_reg_i]);
        end
      end
      XFER: begin
        uop_reg_addr_o  = (low_idx == 4'd8) ? ((op_q == OP_PUSH) ? 4'd14 : 4'd15) : low_idx;
        uop_base_addr_o = base_q;
        uop_offset_o    = {idx_q, 2'b00};
        uop_is_load_o   = (op_q == OP_POP) || (op_q == OP_LDM);
`ifdef LSM_SEPARATE_WB_EN
        uop_last_o      = last_xfer && !wb_req_q;
`else
        uop_last_o      = last_xfer;
        uop_is_wb_o     = last_xfer && wb_req_q;
`endif
        if (advance_i) begin
          pending_d = pending_q & ~low_onehot;
          idx_d     = idx_q + 4'd1;
          if (last_xfer) begin
`ifdef LSM_SEPARATE_WB_EN
            state_d = wb_req_q ? WB : IDLE;
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef LSM_SEPARATE_WB_EN
      WB: begin
        uop_reg_addr_o  = base_q;
        uop_base_addr_o = base_q;
        uop_is_wb_o     = 1'b1;
        uop_last_o      = 1'b1;
        if (advance_i) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsm_uop_sequencer.sv
// Self-checking bench for lsm_uop_sequencer: a queue-based reference model of
// the expected micro-op stream, checked every cycle, plus directed scenarios.
module tb_lsm_uop_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [2:0] base_reg;
  logic [8:0] reg_list;
  logic       advance;
  logic       busy, stall, uvalid, is_load, is_wb, last;
  logic [3:0] reg_addr, base_addr;
  logic [5:0] offset, total_bytes;

  lsm_uop_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .base_reg_i(base_reg),
    .reg_list_i(reg_list), .advance_i(advance), .busy_o(busy), .stall_o(stall),
    .uop_valid_o(uvalid), .uop_reg_addr_o(reg_addr), .uop_base_addr_o(base_addr),
    .uop_offset_o(offset), .uop_is_load_o(is_load), .uop_is_wb_o(is_wb),
    .uop_last_o(last), .total_bytes_o(total_bytes)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    int r;
    int b;
    int off;
    int ld;
    int wb;
    int last;
  } uop_t;

  uop_t q[$];
  int   m_total = 0;

  function automatic logic [8:0] eff_of(input logic [1:0] o, input logic [8:0] l);
    return (o >= 2) ? {1'b0, l[7:0]} : l;
  endfunction

  // Expected stream: one transfer per set bit ascending, then writeback handling.
  task automatic build(input logic [1:0] o, input logic [2:0] rn, input logic [8:0] l);
    logic [8:0] e;
    int k, base_a, wb_req;
    uop_t u;
    e = eff_of(o, l);
    base_a = (o >= 2) ? int'(rn) : 13;
    wb_req = (o == 2'b11 && l[rn]) ? 0 : 1;
    k = 0;
    q.delete();
    for (int i = 0; i < 9; i++) begin
      if (e[i]) begin
        u.r    = (i < 8) ? i : ((o == 2'b00) ? 14 : 15);
        u.b    = base_a;
        u.off  = 4 * k;
        u.ld   = (o == 2'b01 || o == 2'b11) ? 1 : 0;
        u.wb   = 0;
        u.last = 0;
        q.push_back(u);
        k++;
      end
    end
    m_total = 4 * k;
`ifdef LSM_SEPARATE_WB_EN
    if (wb_req != 0) begin
      u.r = base_a; u.b = base_a; u.off = 0; u.ld = 0; u.wb = 1; u.last = 1;
      q.push_back(u);
    end else begin
      q[q.size()-1].last = 1;
    end
`else
    q[q.size()-1].last = 1;
    q[q.size()-1].wb   = wb_req;
`endif
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_total = 0;
    end else if (q.size() != 0) begin
      if (advance) void'(q.pop_front());
    end else if (start && eff_of(op, reg_list) != '0) begin
      build(op, base_reg, reg_list);
    end
  end

  always @(negedge clk) begin
    int mb, exp_stall;
    mb = (q.size() != 0) ? 1 : 0;
    exp_stall = (!rst && (mb == 1 || (start && eff_of(op, reg_list) != '0))) ? 1 : 0;
    chk("busy", int'(busy), mb);
    chk("uop_valid", int'(uvalid), mb);
    chk("stall", int'(stall), exp_stall);
    chk("total_bytes", int'(total_bytes), mb ? m_total : 0);
    if (mb == 1) begin
      chk("reg_addr", int'(reg_addr), q[0].r);
      chk("base_addr", int'(base_addr), q[0].b);
      chk("offset", int'(offset), q[0].off);
      chk("is_load", int'(is_load), q[0].ld);
      chk("is_wb", int'(is_wb), q[0].wb);
      chk("last", int'(last), q[0].last);
    end else begin
      chk("idle_fields", int'({reg_addr, base_addr, offset, is_load, is_wb, last}), 0);
    end
  end

  task automatic drive_start(input logic [1:0] o, input logic [2:0] rn, input logic [8:0] l);
    op = o; base_reg = rn; reg_list = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_idle_timeout"}, int'(busy), 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, int'({busy, stall, uvalid, is_load, is_wb, last}), 0);
    chk({name, "_fields"}, int'({reg_addr, base_addr, offset, total_bytes}), 0);
  endtask

`ifdef LSM_SEPARATE_WB_EN
  localparam int PUSH_UOPS = 4;
`else
  localparam int PUSH_UOPS = 3;
`endif

  initial begin
    int cnt, wbc, ldc;
    rst = 1'b1; start = 1'b0; op = '0; base_reg = '0; reg_list = '0; advance = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // PUSH {R0,R4,LR} with continuous advance
    advance = 1'b1;
    drive_start(2'b00, 3'd0, 9'h111);
    chk("push_model_len", q.size(), PUSH_UOPS);
    chk("push_model_r0", q[0].r, 0);
    chk("push_model_r1", q[1].r, 4);
    chk("push_model_r2", q[2].r, 14);
    chk("push_model_off2", q[2].off, 8);
    chk("push_model_total", m_total, 12);
    chk("push_total_bytes", int'(total_bytes), 12);
    chk("push_base", int'(base_addr), 13);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    chk("push_busy_cycles", cnt, PUSH_UOPS);
    @(posedge clk); #1;

    // LDM R2 {R2,R3}: base reloaded, never a writeback
    drive_start(2'b11, 3'd2, 9'h00C);
    wbc = 0; ldc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      wbc += int'(is_wb);
      ldc += int'(uvalid && is_load);
    end
    chk("ldm_wb_count", wbc, 0);
    chk("ldm_load_count", ldc, 2);
    @(posedge clk); #1;

    // STM R1 {R0} held without advance
    advance = 1'b0;
    drive_start(2'b10, 3'd1, 9'h001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stm_hold_stall", int'(stall), 1);
      chk("stm_hold_reg", int'(reg_addr), 0);
      chk("stm_hold_base", int'(base_addr), 1);
    end
    @(posedge clk); #1;
    advance = 1'b1;
    wait_idle("stm");

    // Empty effective list (STM ignores bit8)
    op = 2'b10; base_reg = 3'd3; reg_list = 9'h100; start = 1'b1;
    #1;
    chk("empty_stall", int'(stall), 0);
    chk("empty_valid", int'(uvalid), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("empty_busy", int'(busy), 0);

    // Start while busy is ignored
    advance = 1'b0;
    drive_start(2'b00, 3'd0, 9'h003);
    @(posedge clk); #1;
    drive_start(2'b10, 3'd5, 9'h0FF);
    chk("midstart_reg", int'(reg_addr), 0);
    chk("midstart_base", int'(base_addr), 13);
    advance = 1'b1;
    wait_idle("midstart");

    // Back-to-back: start held high across sequences
    op = 2'b01; base_reg = 3'd0; reg_list = 9'h100; start = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("b2b");

    // Alternating advance over a few directed lists
    for (int t = 0; t < 3; t++) begin
      logic [1:0] ops [3];
      logic [8:0] lsts [3];
      ops[0] = 2'b11; lsts[0] = 9'h0FE;
      ops[1] = 2'b10; lsts[1] = 9'h1FF;
      ops[2] = 2'b01; lsts[2] = 9'h180;
      drive_start(ops[t], 3'd0 + 3'(t * 3), lsts[t]);
      for (int c = 0; c < 40 && busy; c++) begin
        advance = c[0];
        @(posedge clk); #1;
      end
      advance = 1'b1;
      wait_idle("alt");
    end

    // Asynchronous reset in the middle of POP {R0-R7,PC}
    drive_start(2'b01, 3'd0, 9'h1FF);
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    drive_start(2'b01, 3'd0, 9'h1FF);
    @(negedge clk);
    chk("post_rst_reg", int'(reg_addr), 0);
    chk("post_rst_off", int'(offset), 0);
    chk("post_rst_total", int'(total_bytes), 36);
    wait_idle("post_rst");

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsm_uop_sequencer.md
LSM_UOP_SEQUENCER -- requirements
Module: lsm_uop_sequencer

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_i  input  1  asynchronous, active-high reset.
REQ-003 start_i  input  1  decode presents a multi-register instruction this cycle.
REQ-004 op_i  input  2  00 PUSH, 01 POP, 10 STM, 11 LDM; sampled when start_i=1.
REQ-005 base_reg_i  input  3  Rn for STM/LDM; ignored for PUSH/POP.
REQ-006 reg_list_i  input  9  bits[7:0] select R0-R7; bit8 selects LR (PUSH) or PC (POP); bit8 ignored for STM/LDM.
REQ-007 advance_i  input  1  downstream accepts the current micro-op this cycle.
REQ-008 busy_o  output  1  sequence in progress.
REQ-009 stall_o  output  1  hold fetch/decode.
REQ-010 uop_valid_o  output  1  micro-op fields valid.
REQ-011 uop_reg_addr_o  output  4  transfer register (0-7, 14=LR, 15=PC), or base register for writeback micro-op.
REQ-012 uop_base_addr_o  output  4  13 (SP) for PUSH/POP, else {1'b0,base_reg_i}.
REQ-013 uop_offset_o  output  6  byte offset from start address, 4*k for k-th transfer (k from 0).
REQ-014 uop_is_load_o  output  1  1 for POP/LDM transfer micro-ops.
REQ-015 uop_is_wb_o  output  1  micro-op is the base writeback.
REQ-016 uop_last_o  output  1  final micro-op of sequence.
REQ-017 total_bytes_o  output  6  4*popcount of effective list, held for whole sequence.

Function
REQ-018 States IDLE, XFER, WB; IDLE->XFER on start_i with non-empty effective list while IDLE.
REQ-019 start_i while busy_o=1 shall be ignored.
REQ-020 Empty effective list: start_i ignored, no micro-op, state stays IDLE.
REQ-021 stall_o shall equal busy_o OR (start_i AND effective list non-empty AND state IDLE).
REQ-022 First micro-op valid cycle after start_i; fields registered, stable until advance_i.
REQ-023 Registers issued ascending order (R0..R7, then LR/PC); one per advance_i handshake.
REQ-024 advance_i with uop_valid_o=0 shall have no effect.
REQ-025 PUSH: start address SP-total_bytes_o; POP/STM/LDM: start address base; uop_offset_o relative to that.
REQ-026 Pending-list register clears lowest set bit on each accepted transfer; offset increments by 4.
REQ-027 Base writeback required for PUSH, POP, STM, and LDM whose list excludes base_reg_i; LDM with base in list: no writeback.
REQ-028 After last accepted micro-op: XFER->IDLE (or WB->IDLE), busy_o=0 next cycle.
REQ-029 Back-to-back: start_i accepted in the cycle after busy_o falls.

Reset
REQ-030 rst_i=1 asynchronously forces IDLE; busy_o, stall_o, uop_valid_o, uop_is_load_o, uop_is_wb_o, uop_last_o=0; uop_reg_addr_o, uop_base_addr_o, uop_offset_o, total_bytes_o=0.
REQ-031 Reset mid-sequence abandons remaining micro-ops; no partial state survives release.

Configuration
REQ-032 Macro LSM_SEPARATE_WB_EN defined: when writeback required, XFER->WB after last transfer; WB issues one micro-op with uop_is_wb_o=1, uop_reg_addr_o=base, uop_offset_o=0, uop_last_o=1; last transfer has uop_last_o=0.
REQ-033 LSM_SEPARATE_WB_EN undefined: WB state absent; uop_is_wb_o=1 together with uop_last_o=1 on the final transfer when writeback required, else uop_is_wb_o=0.

Verification
REQ-034 PUSH list 9'h111 (R0,R4,LR), advance_i=1 -> regs 0,4,14, offsets 0,4,8, total_bytes_o=12, base 13, busy_o 3 cycles (4 with LSM_SEPARATE_WB_EN).
REQ-035 LDM Rn=2, list 8'h0C (R2,R3) -> two loads, uop_is_wb_o never 1.
REQ-036 STM Rn=1, list 8'h01, advance_i held low 5 cycles -> micro-op fields stable, stall_o=1 throughout.
REQ-037 start_i with list 0 -> stall_o=0, uop_valid_o=0; start_i mid-sequence -> ignored, sequence unchanged.
REQ-038 rst_i asserted between edges during POP list 9'h1FF -> all outputs 0 immediately; after release, new start_i sequences from R0.
